// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - two-stage immediate extension pipeline with valid/ready handshakes
//
// Purpose: captures a raw 26-bit instruction immediate plus a format select in
// stage S1, decodes and extends it into stage S2, and presents it to a consumer
// with a valid/ready handshake. Illegal requests produce zero with ImmErr set
// and are counted in a saturating 8-bit counter.
//
// Ports:
//   Clk       in   clock, all state on rising edge
//   Reset     in   synchronous active-high reset
//   Imm26     in   raw instruction bits [25:0]
//   Ctrl      in   format: 0=I 1=D 2=B 3=CB 4=IW(MOVZ), 5..7 illegal
//   InValid   in   Imm26/Ctrl valid this cycle
//   InReady   out  block accepts input this cycle
//   BusImm    out  extended immediate, DATA_WIDTH bits
//   ImmErr    out  BusImm came from an illegal request
//   OutValid  out  BusImm/ImmErr valid
//   OutReady  in   consumer accepts output this cycle
//   ErrCount  out  saturating count of illegal requests entering S2
module imm_extend_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int BR_SHIFT   = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [25:0]           Imm26,
  input  logic [2:0]            Ctrl,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [DATA_WIDTH-1:0] BusImm,
  output logic                  ImmErr,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [7:0]            ErrCount
);

  logic                  s1_valid_q, s1_valid_d;
  logic [25:0]           s1_imm_q, s1_imm_d;
  logic [2:0]            s1_ctrl_q, s1_ctrl_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_imm_q, s2_imm_d;
  logic                  s2_err_q, s2_err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  adv2;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] ext;
  logic                  illegal;
  logic [1:0]            hw;

  // S2 can take a new entry when it is empty or its entry leaves this cycle;
  // S1 can take new input when it is empty or its entry moves on to S2.
  assign adv2     = !s2_valid_q || OutReady;
  assign in_ready = !s1_valid_q || adv2;

  // Decode of the S1 entry. Illegal requests leave ext at zero.
  always_comb begin
    ext     = '0;
    illegal = 1'b0;
    hw      = s1_imm_q[22:21];
    case (s1_ctrl_q)
      3'd0: ext = {{(DATA_WIDTH-12){1'b0}}, s1_imm_q[21:10]};
      3'd1: ext = {{(DATA_WIDTH-9){s1_imm_q[20]}}, s1_imm_q[20:12]};
      3'd2: begin
        // Shift first, then sign-extend from the new top bit.
        if (BR_SHIFT != 0)
          ext = {{(DATA_WIDTH-28){s1_imm_q[25]}}, s1_imm_q, 2'b00};
        else
          ext = {{(DATA_WIDTH-26){s1_imm_q[25]}}, s1_imm_q};
      end
      3'd3: begin
        if (BR_SHIFT != 0)
          ext = {{(DATA_WIDTH-21){s1_imm_q[23]}}, s1_imm_q[23:5], 2'b00};
        else
          ext = {{(DATA_WIDTH-19){s1_imm_q[23]}}, s1_imm_q[23:5]};
      end
      3'd4: begin
        // A 32-bit result cannot hold a halfword placed at bit 32 or 48.
        if (DATA_WIDTH == 32 && hw[1])
          illegal = 1'b1;
        else
          ext = {{(DATA_WIDTH-16){1'b0}}, s1_imm_q[20:5]} << {hw, 4'b0000};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_ctrl_d  = s1_ctrl_q;
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    if (in_ready) begin
      s1_valid_d = InValid;
      if (InValid) begin
        s1_imm_d  = Imm26;
        s1_ctrl_d = Ctrl;
      end
    end

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_imm_d = ext;
        s2_err_d = illegal;
        if (illegal && err_cnt_q != 8'hFF)
          err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_ctrl_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_ctrl_q  <= s1_ctrl_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign InReady  = in_ready;
  assign BusImm   = s2_imm_q;
  assign ImmErr   = s2_err_q;
  assign OutValid = s2_valid_q;
  assign ErrCount = err_cnt_q;

endmodule
